// File: rtl/char_map_if.sv
// PicoBlaze I/O port and VGA scan-position bundle for the character-map controller.
interface char_map_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic       read_strobe;
    logic [9:0] Qh;
    logic [9:0] Qv;
    logic [5:0] char_code;
    logic [7:0] status;
    logic       busy;

    modport master (
        output port_id, out_port, write_strobe, read_strobe, Qh, Qv,
        input  char_code, status, busy
    );

    modport slave (
        input  port_id, out_port, write_strobe, read_strobe, Qh, Qv,
        output char_code, status, busy
    );
endinterface

// File: rtl/char_map_ctrl.sv
// Character-map RAM controller: shares one single-port 80x60 glyph-code RAM
// between VGA fetches, buffered PicoBlaze writes and full-screen clears.
module char_map_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 60
) (
    input  logic      reloj,
    input  logic      resetM,
    char_map_if.slave bus
);
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    typedef struct packed {
        logic [5:0] row;
        logic [6:0] col;
        logic [5:0] code;
    } wr_entry_t;

    // Row-major cell address with the fixed 80-column stride (64 + 16).
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row, input logic [6:0] col);
        return (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
    endfunction

    logic [1:0]        state_q, state_d;
    logic              init_done_q;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [6:0]        col_q;
    logic [5:0]        row_q;
    wr_entry_t         fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, busy_q;
    logic [5:0]        char_code_q;
    logic [5:0]        mem [CELLS];

    logic              wr_col, wr_row, push_req, clr_cmd, ovf_rd;
    logic              fetch, coord_ok, full, pop, push_ok, clr_we;
    logic [ADDR_W-1:0] fetch_addr;
    wr_entry_t         head;
    logic              unused_bits;

    assign wr_col      = bus.write_strobe && (bus.port_id == 8'h10);
    assign wr_row      = bus.write_strobe && (bus.port_id == 8'h11);
    assign push_req    = bus.write_strobe && (bus.port_id == 8'h12);
    assign clr_cmd     = bus.write_strobe && (bus.port_id == 8'h13);
    assign ovf_rd      = bus.read_strobe  && (bus.port_id == 8'h14);
    assign unused_bits = bus.out_port[7];

    assign fetch      = (bus.Qh[2:0] == 3'd0) && (bus.Qh < 10'd640) && (bus.Qv < 10'd480);
    assign fetch_addr = cell_addr(bus.Qv[9:3], bus.Qh[9:3]);
    assign coord_ok   = (col_q < 7'(COLS)) && (row_q < 6'(ROWS));
    assign full       = (count_q == CNT_W'(FIFO_DEPTH));
    assign head       = fifo_q[rd_ptr_q];

    // Video owns the RAM on fetch cycles; a clear-command cycle touches nothing.
    assign pop     = init_done_q && !clr_cmd && (state_q == S_DRAIN) && !fetch && (count_q != '0);
    assign clr_we  = init_done_q && !clr_cmd && (state_q == S_CLEAR) && !fetch;
    assign push_ok = push_req && coord_ok && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (clr_cmd)
            count_d = '0;
        else if (push_ok && !pop)
            count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop)
            count_d = count_q - CNT_W'(1);
    end

    // Next-state logic; the first cycle out of reset forces a screen clear.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (!init_done_q || clr_cmd) begin
            state_d   = S_CLEAR;
            clr_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE:  if (count_d != '0) state_d = S_DRAIN;
                S_DRAIN: if (count_d == '0) state_d = S_IDLE;
                S_CLEAR: if (clr_we) begin
                    if (clr_cnt_q == ADDR_W'(CELLS - 1))
                        state_d = (count_d != '0) ? S_DRAIN : S_IDLE;
                    else
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            state_q     <= S_IDLE;
            init_done_q <= 1'b0;
            clr_cnt_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= 1'b1;
            clr_cnt_q   <= clr_cnt_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM) begin
            col_q      <= '0;
            row_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_col) col_q <= bus.out_port[6:0];
            if (wr_row) row_q <= bus.out_port[5:0];
            if (clr_cmd) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            // A fresh overflow beats a same-cycle status read.
            if (push_req && coord_ok && full && !pop)
                overflow_q <= 1'b1;
            else if (ovf_rd)
                overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge reloj) begin
        if (push_ok) fifo_q[wr_ptr_q] <= {row_q, col_q, bus.out_port[5:0]};
    end

    always_ff @(posedge reloj) begin
        if (clr_we)
            mem[clr_cnt_q] <= '0;
        else if (pop)
            mem[cell_addr(7'(head.row), head.col)] <= head.code;
    end

    always_ff @(posedge reloj or negedge resetM) begin
        if (!resetM)
            char_code_q <= '0;
        else if (fetch)
            char_code_q <= mem[fetch_addr];
    end

    assign bus.char_code = char_code_q;
    assign bus.status    = {6'b0, overflow_q, busy_q};
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_char_map_ctrl.sv
// Self-checking bench for char_map_ctrl against a cell-array plus pending-queue model.
module tb_char_map_ctrl;
    localparam int DEPTH = 4;
    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int CELLS = COLS * ROWS;

    typedef struct packed {
        logic [6:0] col;
        logic [5:0] row;
        logic [5:0] code;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    char_map_if bus ();

    char_map_ctrl #(.FIFO_DEPTH(DEPTH), .COLS(COLS), .ROWS(ROWS)) dut (
        .reloj  (clk),
        .resetM (rst_n),
        .bus    (bus)
    );

    int         errors = 0;
    int         checks = 0;
    logic [5:0] ram_model [CELLS];
    ent_t       pend [$];
    bit         in_clear  = 1'b0;
    bit         ovf_model = 1'b0;
    int         rand_cells [$];
    int         scan_cells [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic video_idle();
        bus.Qh = 10'd700;
        bus.Qv = 10'd500;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] data);
        bus.port_id      = port;
        bus.out_port     = data;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
    endtask

    function automatic void model_clear();
        foreach (ram_model[i]) ram_model[i] = 6'd0;
        pend.delete();
        in_clear = 1'b1;
    endfunction

    function automatic void model_end_clear();
        foreach (pend[i]) ram_model[int'(pend[i].row) * COLS + int'(pend[i].col)] = pend[i].code;
        pend.delete();
        in_clear = 1'b0;
    endfunction

    // Outside a clear the FIFO drains between pushes, so writes land directly.
    function automatic void model_push(input int col, input int row, input int code);
        if (col >= COLS || row >= ROWS) return;
        if (!in_clear)
            ram_model[row * COLS + col] = 6'(code);
        else if (pend.size() >= DEPTH)
            ovf_model = 1'b1;
        else
            pend.push_back('{col: 7'(col), row: 6'(row), code: 6'(code)});
    endfunction

    task automatic push(input int col, input int row, input int code);
        wr(8'h10, 8'(col));
        wr(8'h11, 8'(row));
        wr(8'h12, 8'(code));
        model_push(col, row, code);
    endtask

    task automatic clear_cmd();
        wr(8'h13, 8'($urandom));
        model_clear();
    endtask

    task automatic fetch_check(input int row, input int col, input string tag);
        bus.Qv = 10'(row * 8);
        bus.Qh = 10'(col * 8);
        tick();
        video_idle();
        check(tag, 32'(bus.char_code), 32'(ram_model[row * COLS + col]));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic scan_all(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fetch_check(r, c, tag);
    endtask

    initial begin
        int hi;
        int c;
        int r;
        bus.port_id      = 8'h00;
        bus.out_port     = 8'h00;
        bus.write_strobe = 1'b0;
        bus.read_strobe  = 1'b0;
        video_idle();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("reset_char_code", 32'(bus.char_code), 32'd0);
        check("reset_status",    32'(bus.status),    32'd0);
        check("reset_busy",      32'(bus.busy),      32'd0);

        // Automatic clear after reset: busy for exactly 4800 cycles.
        rst_n = 1'b1;
        model_clear();
        hi = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (i == 0) check("busy_first_edge", 32'(bus.busy), 32'd1);
            if (bus.busy === 1'b1) hi++;
        end
        check("clear_busy_cycles", 32'(hi), 32'd4800);
        model_end_clear();
        scan_all("zero_scan");

        // Single write then fetch of cell 165.
        push(5, 2, 8'h27);
        check("busy_after_push", 32'(bus.busy), 32'd1);
        tick();
        check("busy_after_pop", 32'(bus.busy), 32'd0);
        fetch_check(2, 5, "fetch_165");

        // Out-of-range coordinates are discarded without a flag.
        push(80, 3, 8'h11);
        check("oor_col_busy",   32'(bus.busy),   32'd0);
        check("oor_col_status", 32'(bus.status), 32'd0);
        push(3, 60, 8'h12);
        check("oor_row_busy",   32'(bus.busy),   32'd0);
        check("oor_row_status", 32'(bus.status), 32'd0);
        fetch_check(4, 0, "oor_col_ram");
        fetch_check(3, 3, "oor_row_ram");

        // Random pushes with occasional out-of-range coordinates.
        for (int k = 0; k < 40; k++) begin
            c = int'($urandom_range(0, 79));
            r = int'($urandom_range(0, 59));
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) c = int'($urandom_range(80, 127));
                else                           r = int'($urandom_range(60, 63));
            end
            push(c, r, int'($urandom_range(0, 43)));
            if (c < COLS && r < ROWS) rand_cells.push_back(r * COLS + c);
        end
        tick();
        check("rand_status", 32'(bus.status), {30'd0, ovf_model, 1'b0});
        foreach (rand_cells[i]) fetch_check(rand_cells[i] / COLS, rand_cells[i] % COLS, "rand_cell");

        // Five pushes during CLEAR: four queue, the fifth overflows.
        clear_cmd();
        check("clear_status", 32'(bus.status), 32'h01);
        for (int k = 0; k < 5; k++) push(k, 0, k + 1);
        check("ovf_status", 32'(bus.status), {30'd0, ovf_model, 1'b1});
        check("ovf_status_const", 32'(bus.status), 32'h03);
        wait_idle(6000, "ovf_clear_done");
        model_end_clear();
        check("ovf_sticky", 32'(bus.status), {30'd0, ovf_model, 1'b0});
        bus.port_id     = 8'h14;
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        ovf_model = 1'b0;
        check("ovf_cleared", 32'(bus.status), 32'h00);
        for (int k = 0; k < 5; k++) fetch_check(0, k, "ovf_cell");

        // A second clear flushes entries queued behind the first one.
        clear_cmd();
        push(10, 7, 8'h15);
        push(11, 7, 8'h16);
        push(12, 7, 8'h17);
        clear_cmd();
        push(40, 30, 8'h2A);
        wait_idle(6000, "flush_clear_done");
        model_end_clear();
        scan_all("flush_scan");

        // Continuous visible scan of row 10 while pushes target other rows.
        for (int k = 0; k < COLS; k++) push(k, 10, int'($urandom_range(1, 43)));
        tick();
        fork
            begin
                for (int v = 80; v < 88; v++)
                    for (int h = 0; h < 640; h++) begin
                        bus.Qv = 10'(v);
                        bus.Qh = 10'(h);
                        tick();
                        check("scan_fetch", 32'(bus.char_code), 32'(ram_model[10 * COLS + h / 8]));
                    end
                video_idle();
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    int pc;
                    int pr;
                    pc = int'($urandom_range(0, 79));
                    pr = int'($urandom_range(20, 59));
                    push(pc, pr, int'($urandom_range(0, 43)));
                    scan_cells.push_back(pr * COLS + pc);
                end
            end
        join
        wait_idle(100, "scan_drain_done");
        foreach (scan_cells[i]) fetch_check(scan_cells[i] / COLS, scan_cells[i] % COLS, "scan_push_cell");

        // Asynchronous reset in the middle of a clear.
        fetch_check(10, 5, "pre_reset_fetch");
        clear_cmd();
        repeat (50) tick();
        check("midclear_busy", 32'(bus.busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_busy",      32'(bus.busy),      32'd0);
        check("async_rst_char_code", 32'(bus.char_code), 32'd0);
        check("async_rst_status",    32'(bus.status),    32'd0);
        tick();
        rst_n = 1'b1;
        model_clear();
        ovf_model = 1'b0;
        tick();
        check("post_reset_busy", 32'(bus.busy), 32'd1);
        wait_idle(6000, "post_reset_clear");
        model_end_clear();
        fetch_check(10, 5, "post_reset_zero");
        fetch_check(30, 40, "post_reset_zero2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
